// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from the async FIFO read port and sends
// them as UART frames (start, 8 data LSB first, optional parity, stop).
module fifo_uart_tx #(
    parameter int DSIZE = 8,
    parameter int PRE_W = 6
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [DSIZE-1:0] rdata,
    input  logic             rempty,
    output logic             rinc,
    input  logic [PRE_W-1:0] PRESCALE,
    input  logic             PAR_EN,
    input  logic             PAR_TYP,
    output logic             TX_OUT,
    output logic             busy
);

    localparam int CW = (DSIZE > 1) ? $clog2(DSIZE) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state;
    logic [DSIZE-1:0] shift_reg;
    logic [DSIZE-1:0] byte_reg;
    logic [PRE_W-1:0] pre_reg;
    logic [PRE_W-1:0] bit_cnt;
    logic [CW-1:0]    data_cnt;
    logic             par_en_r;
    logic             par_typ_r;
    logic             bit_end;
    logic [PRE_W-1:0] pre_eff;

    // Pop only while idle; held off during reset so nothing is lost.
    assign rinc    = (state == IDLE) & ~rempty & ~RST;
    assign pre_eff = (PRESCALE == '0) ? PRE_W'(1) : PRESCALE;
    assign bit_end = (bit_cnt == pre_reg - PRE_W'(1));

    // Frame sequencer with registered line and busy outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            TX_OUT    <= 1'b1;
            busy      <= 1'b0;
            shift_reg <= '0;
            byte_reg  <= '0;
            pre_reg   <= '0;
            bit_cnt   <= '0;
            data_cnt  <= '0;
            par_en_r  <= 1'b0;
            par_typ_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    TX_OUT   <= 1'b1;
                    busy     <= 1'b0;
                    bit_cnt  <= '0;
                    data_cnt <= '0;
                    if (!rempty) begin
                        shift_reg <= rdata;
                        byte_reg  <= rdata;
                        pre_reg   <= pre_eff;
                        par_en_r  <= PAR_EN;
                        par_typ_r <= PAR_TYP;
                        state     <= START;
                        TX_OUT    <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        state   <= DATA;
                        TX_OUT  <= shift_reg[0];
                    end else begin
                        bit_cnt <= bit_cnt + PRE_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        bit_cnt   <= '0;
                        shift_reg <= shift_reg >> 1;
                        if (data_cnt == CW'(DSIZE - 1)) begin
                            data_cnt <= '0;
                            if (par_en_r) begin
                                state  <= PARITY;
                                TX_OUT <= (^byte_reg) ^ par_typ_r;
                            end else begin
                                state  <= STOP;
                                TX_OUT <= 1'b1;
                            end
                        end else begin
                            data_cnt <= data_cnt + CW'(1);
                            TX_OUT   <= shift_reg[1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + PRE_W'(1);
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        state   <= STOP;
                        TX_OUT  <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + PRE_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        state   <= IDLE;
                        TX_OUT  <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + PRE_W'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    TX_OUT <= 1'b1;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed checks of fifo_uart_tx framing, pops,
// prescale handling, parity and reset behaviour.
module tb_fifo_uart_tx;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] rdata;
    logic       rempty;
    logic       rinc;
    logic [5:0] PRESCALE;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       TX_OUT;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:31];
    int rd_ptr = 0;
    int wr_ptr = 0;
    int cyc = 0;
    int pops = 0;
    int pop_cyc[$];
    int p0;
    int base;

    fifo_uart_tx #(.DSIZE(8), .PRE_W(6)) dut (
        .CLK(CLK),
        .RST(RST),
        .rdata(rdata),
        .rempty(rempty),
        .rinc(rinc),
        .PRESCALE(PRESCALE),
        .PAR_EN(PAR_EN),
        .PAR_TYP(PAR_TYP),
        .TX_OUT(TX_OUT),
        .busy(busy)
    );

    always #5 CLK = ~CLK;

    // FIFO read side model: combinational head, pop on rinc edge.
    assign rdata  = mem[rd_ptr[4:0]];
    assign rempty = (rd_ptr == wr_ptr);

    // Count cycles and log each pop with its cycle number.
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (rinc) begin
            rd_ptr <= rd_ptr + 1;
            pops   <= pops + 1;
            pop_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(logic [7:0] b);
        mem[wr_ptr[4:0]] = b;
        wr_ptr++;
        #1;
    endtask

    // Called one cycle after the capture edge; ends on the idle cycle.
    task automatic frame(logic [7:0] b, logic pe, logic pt, int p,
                         string tag);
        logic [10:0] bits;
        int n;
        n = pe ? 11 : 10;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = b[i];
        if (pe) bits[9] = (^b) ^ pt;
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < p; c++) begin
                chk({tag, " tx"}, TX_OUT, bits[i]);
                chk({tag, " busy"}, busy, 1);
                chk({tag, " rinc"}, rinc, 0);
                tick();
            end
        end
        chk({tag, " idle_tx"}, TX_OUT, 1);
        chk({tag, " idle_busy"}, busy, 0);
    endtask

    initial begin
        RST      = 1'b1;
        PRESCALE = 6'd4;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;

        // Reset state.
        tick();
        chk("rst_tx", TX_OUT, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rinc", rinc, 0);
        tick();
        RST = 1'b0;
        for (int i = 0; i < 50; i++) begin
            chk("empty_tx", TX_OUT, 1);
            chk("empty_busy", busy, 0);
            chk("empty_rinc", rinc, 0);
            tick();
        end

        // 0xA5, P=4, no parity; settings change mid-frame are ignored.
        p0 = pops;
        push(8'hA5);
        chk("a5_rinc", rinc, 1);
        tick();
        PRESCALE = 6'd7;
        PAR_EN   = 1'b1;
        PAR_TYP  = 1'b1;
        chk("a5_pop", pops - p0, 1);
        frame(8'hA5, 1'b0, 1'b0, 4, "a5");
        chk("a5_rinc_after", rinc, 0);
        chk("a5_pops", pops - p0, 1);

        // 0x07 with even then odd parity, P=2.
        PRESCALE = 6'd2;
        PAR_EN   = 1'b1;
        PAR_TYP  = 1'b0;
        push(8'h07);
        tick();
        frame(8'h07, 1'b1, 1'b0, 2, "par_even");
        PAR_TYP = 1'b1;
        push(8'h07);
        tick();
        frame(8'h07, 1'b1, 1'b1, 2, "par_odd");

        // Three back-to-back bytes, P=1.
        PRESCALE = 6'd1;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        p0   = pops;
        base = pop_cyc.size();
        push(8'h11);
        push(8'h22);
        push(8'h33);
        tick();
        frame(8'h11, 1'b0, 1'b0, 1, "b2b_11");
        chk("b2b_rinc1", rinc, 1);
        tick();
        frame(8'h22, 1'b0, 1'b0, 1, "b2b_22");
        chk("b2b_rinc2", rinc, 1);
        tick();
        frame(8'h33, 1'b0, 1'b0, 1, "b2b_33");
        chk("b2b_rinc_end", rinc, 0);
        chk("b2b_pops", pops - p0, 3);
        chk("b2b_gap1", pop_cyc[base+1] - pop_cyc[base], 11);
        chk("b2b_gap2", pop_cyc[base+2] - pop_cyc[base+1], 11);

        // PRESCALE=0 behaves as one cycle per bit.
        PRESCALE = 6'd0;
        push(8'hFF);
        tick();
        frame(8'hFF, 1'b0, 1'b0, 1, "pre0");

        // Reset during data bit 3 of 0x3C, then 0x5A sent intact.
        PRESCALE = 6'd4;
        p0 = pops;
        push(8'h3C);
        push(8'h5A);
        tick();
        repeat (17) tick();
        chk("mid_tx", TX_OUT, 1);
        chk("mid_busy", busy, 1);
        RST = 1'b1;
        #1;
        chk("rst_mid_tx", TX_OUT, 1);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_rinc", rinc, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_hold_rinc", rinc, 0);
            chk("rst_hold_busy", busy, 0);
        end
        chk("rst_pops", pops - p0, 1);
        RST = 1'b0;
        #1;
        chk("rel_rinc", rinc, 1);
        tick();
        chk("rel_pop", pops - p0, 2);
        frame(8'h5A, 1'b0, 1'b0, 4, "after_rst");
        chk("after_rst_rinc", rinc, 0);
        chk("after_rst_pops", pops - p0, 2);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Read-side consumer of the asynchronous FIFO, running in the FIFO's read-clock domain.
- Pops bytes from the FIFO read port (rdata/rempty/rinc) and serializes each one as a UART frame on TX_OUT: start bit, 8 data bits LSB first, optional parity, stop bit.
- Sits between the FIFO read port and the UART line; it is the transmit-side counterpart of the FIFO write path.

Parameters:
- DSIZE, 8, data width of FIFO words and UART data field
- PRE_W, 6, width of the PRESCALE input

Ports:
- CLK  input  1  read-domain clock, the same clock as the FIFO rclk
- RST  input  1  asynchronous, active-high reset
- rdata  input  DSIZE  FIFO read data; combinational from FIFO memory, valid whenever rempty=0
- rempty  input  1  FIFO empty flag
- rinc  output  1  FIFO pop strobe
- PRESCALE  input  PRE_W  CLK cycles per UART bit
- PAR_EN  input  1  1 = parity bit inserted
- PAR_TYP  input  1  0 = even parity, 1 = odd parity
- TX_OUT  output  1  serial line, idle high
- busy  output  1  frame in progress

Behaviour:
- Decided interface rule: one clock; reset is asynchronous and active-high.
- Reset (RST=1, async): state=IDLE, TX_OUT=1, busy=0, rinc=0, all counters=0.
- States: IDLE, START, DATA, PARITY, STOP.
- rinc is combinational: rinc = (state==IDLE) & ~rempty. It is never asserted in any other state or while RST=1.
- IDLE with rempty=0, at the next rising edge:
  - capture rdata into the shift register; the FIFO pops on this same edge;
  - sample PRESCALE, PAR_EN, PAR_TYP into frame-local registers;
  - go to START.
- PRESCALE, PAR_EN and PAR_TYP changes mid-frame have no effect on the current frame.
- TX_OUT and busy are registered. They reflect the new state from the first cycle after the capture edge.
- Bit timing:
  - each bit is held for P cycles, where P = captured PRESCALE, and P = 1 if PRESCALE = 0;
  - a bit counter runs 0..P-1 and a transition occurs when it reaches P-1.
- START: TX_OUT=0 for P cycles, then go to DATA.
- DATA: TX_OUT = shift_reg[0]. Shift right at the end of each bit. After DSIZE bits go to PARITY if PAR_EN, else to STOP.
- PARITY: TX_OUT = ^captured_byte XOR PAR_TYP, held for P cycles. The value is computed from the captured byte, not the shifted register.
- STOP: TX_OUT=1 for P cycles, then go to IDLE.
- busy = 1 in START, DATA, PARITY and STOP; busy = 0 in IDLE.
- Frame length = (DSIZE + 2 + PAR_EN) * P cycles.
- Back-to-back frames: at least one IDLE cycle (TX_OUT=1) between frames. Period with FIFO non-empty = (DSIZE + 2 + PAR_EN) * P + 1.
- FIFO going empty mid-frame: no effect; the block stays in IDLE afterwards until rempty=0.
- rempty glitching high in IDLE: no pop; rinc follows rempty combinationally.
- Reset mid-frame:
  - TX_OUT returns to 1 immediately;
  - the in-flight byte is discarded, since it was already popped;
  - no rinc until RST deasserts.
  - After RST deasserts, the first possible pop is at the first rising edge.
- Never more than one pop per frame; exactly one pop per frame sent.

Test Plan:
- Reset, then release with rempty=1 -> TX_OUT=1, busy=0, rinc=0 for 50 cycles.
- rdata=0xA5, rempty=0 for one cycle, PRESCALE=4, PAR_EN=0 -> rinc high for exactly 1 cycle; TX_OUT = 0, 1,0,1,0,0,1,0,1, 1, each bit held 4 cycles; busy high for 40 cycles.
- rdata=0x07, PAR_EN=1, PAR_TYP=0, PRESCALE=2 -> parity bit=1; frame 22 cycles. Repeat with PAR_TYP=1 -> parity bit=0.
- FIFO preloaded with 0x11, 0x22, 0x33 (model from rdata/rinc), PRESCALE=1, PAR_EN=0 -> three frames in order; rinc pulses 11 cycles apart; exactly 3 pops.
- PRESCALE=0 with byte 0xFF -> behaves as P=1: 10-cycle frame, start=0, eight data=1, stop=1.
- Assert RST during DATA bit 3 of byte 0x3C -> TX_OUT=1 in the same cycle, busy=0. After release with rempty=0, the next byte pops on the first edge and its frame is transmitted intact.
